// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the sync/timing stage, the drawing client and the frame-buffer RAM.
// Signal names follow the original flat port list.
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8
);
   logic              iFRAME_START;
   logic              iPIX_REQ;
   logic [DATA_W-1:0] oPIX_DATA;
   logic              iWR_REQ;
   logic [ADDR_W-1:0] iWR_ADDR;
   logic [DATA_W-1:0] iWR_DATA;
   logic              oWR_ACK;
   logic              oRAM_EN;
   logic              oRAM_WE;
   logic [ADDR_W-1:0] oRAM_ADDR;
   logic [DATA_W-1:0] oRAM_WDATA;
   logic [DATA_W-1:0] iRAM_RDATA;
   logic [1:0]        oERR;

   modport slave (
      input  iFRAME_START, iPIX_REQ, iWR_REQ, iWR_ADDR, iWR_DATA, iRAM_RDATA,
      output oPIX_DATA, oWR_ACK, oRAM_EN, oRAM_WE, oRAM_ADDR, oRAM_WDATA, oERR
   );

   modport master (
      output iFRAME_START, iPIX_REQ, iWR_REQ, iWR_ADDR, iWR_DATA, iRAM_RDATA,
      input  oPIX_DATA, oWR_ACK, oRAM_EN, oRAM_WE, oRAM_ADDR, oRAM_WDATA, oERR
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display prefetch FIFO fed by sequential reads,
// leftover RAM cycles granted to the drawing client.
module vga_fb_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 8,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 16,
   parameter int LOW_WM     = 4,
   parameter int RD_LAT     = 2
) (
   input logic             CLK,
   input logic             SYNC_RST_N,
   vga_fb_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CRD_W = $clog2(FIFO_DEPTH + RD_LAT) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LVL_W-1:0]  level, level_nxt;
   logic [RD_LAT-1:0] rd_vld;
   logic [ADDR_W-1:0] fetch_addr;
   logic [CRD_W-1:0]  inflight, credit;
   logic              can_read, push, pop, flush;
   logic              rd_issue, wr_grant;

   // Credit counts reads already in the pipe so the FIFO can never overflow.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < RD_LAT; i++)
         inflight = inflight + CRD_W'(rd_vld[i]);
      credit   = CRD_W'(level) + inflight;
      can_read = credit < CRD_W'(FIFO_DEPTH);
   end

   assign flush     = bus.iFRAME_START && (state == S_PRIME || state == S_RUN);
   assign push      = rd_vld[RD_LAT-1] && !flush;
   assign pop       = bus.iPIX_REQ && (level != '0);
   assign level_nxt = flush ? '0 : level + LVL_W'(push) - LVL_W'(pop);

   always_comb begin
      state_nxt = state;
      rd_issue  = 1'b0;
      wr_grant  = 1'b0;
      case (state)
         S_IDLE: begin
            wr_grant = bus.iWR_REQ;
            if (bus.iFRAME_START) state_nxt = S_PRIME;
         end
         S_PRIME: begin
            if (flush) begin
               state_nxt = S_PRIME;
            end else begin
               rd_issue = can_read;
               if (rd_issue && fetch_addr == LAST_ADDR)   state_nxt = S_DONE;
               else if (level_nxt == LVL_W'(FIFO_DEPTH)) state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (flush) begin
               state_nxt = S_PRIME;
            end else if (can_read && (credit < CRD_W'(LOW_WM) || !bus.iWR_REQ)) begin
               rd_issue = 1'b1;
               if (fetch_addr == LAST_ADDR) state_nxt = S_DONE;
            end else begin
               wr_grant = bus.iWR_REQ;
            end
         end
         S_DONE: begin
            wr_grant = bus.iWR_REQ;
            if (bus.iFRAME_START) state_nxt = S_PRIME;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge SYNC_RST_N) begin
      if (!SYNC_RST_N) begin
         state          <= S_IDLE;
         rd_vld         <= '0;
         fetch_addr     <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         bus.oRAM_EN    <= 1'b0;
         bus.oRAM_WE    <= 1'b0;
         bus.oRAM_ADDR  <= '0;
         bus.oRAM_WDATA <= '0;
         bus.oWR_ACK    <= 1'b0;
         bus.oPIX_DATA  <= '0;
         bus.oERR       <= '0;
      end else begin
         state   <= state_nxt;
         rd_vld  <= flush ? '0 : ((rd_vld << 1) | RD_LAT'(rd_issue));
         level   <= level_nxt;
         if (bus.iFRAME_START)
            fetch_addr <= '0;
         else if (rd_issue)
            fetch_addr <= fetch_addr + ADDR_W'(1);

         if (rd_issue) begin
            bus.oRAM_EN   <= 1'b1;
            bus.oRAM_WE   <= 1'b0;
            bus.oRAM_ADDR <= fetch_addr;
         end else if (wr_grant) begin
            bus.oRAM_EN    <= 1'b1;
            bus.oRAM_WE    <= 1'b1;
            bus.oRAM_ADDR  <= bus.iWR_ADDR;
            bus.oRAM_WDATA <= bus.iWR_DATA;
         end else begin
            bus.oRAM_EN <= 1'b0;
            bus.oRAM_WE <= 1'b0;
         end
         bus.oWR_ACK <= wr_grant;

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end

         // A pop on an empty FIFO returns 0 and flags underflow.
         if (bus.iPIX_REQ)
            bus.oPIX_DATA <= pop ? fifo_mem[rd_ptr] : '0;
         bus.oERR <= bus.oERR | {flush, bus.iPIX_REQ && (level == '0)};
      end
   end

   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr] <= bus.iRAM_RDATA;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two requesters: the VGA display pixel stream and a drawing/write client.
- Prefetches pixels into an internal FIFO, so the display sync stage can pop one pixel per active clock with no stalls.
- Gives leftover RAM cycles to the writer.
- Sits between the sync/timing stage and the frame-buffer RAM.

Parameters:
- ADDR_W, 19, RAM address width.
- DATA_W, 8, pixel width.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- FIFO_DEPTH, 16, prefetch FIFO entries (power of 2).
- LOW_WM, 4, level below which display reads take priority over writes.
- RD_LAT, 2, fixed RAM read latency in clocks (>=1).

Ports:
- CLK  in  1  pixel clock
- SYNC_RST_N  in  1  asynchronous active-low reset
- iFRAME_START  in  1  one-clock pulse at the start of vertical blank
- iPIX_REQ  in  1  display pops one pixel this cycle
- oPIX_DATA  out  DATA_W  popped pixel, registered
- iWR_REQ  in  1  writer request; held until acknowledged
- iWR_ADDR  in  ADDR_W  write address
- iWR_DATA  in  DATA_W  write data
- oWR_ACK  out  1  one-clock write acknowledge
- oRAM_EN  out  1  RAM access strobe
- oRAM_WE  out  1  1=write, 0=read
- oRAM_ADDR  out  ADDR_W  RAM address
- oRAM_WDATA  out  DATA_W  RAM write data
- iRAM_RDATA  in  DATA_W  RAM read data
- oERR  out  2  sticky flags: [0] underflow, [1] frame restart while fetching

Behaviour:
- Reset: clock and reset are CLK and SYNC_RST_N; reset is asynchronous, active-low.
  - All outputs 0, state IDLE, FIFO empty, fetch address 0, in-flight pipe cleared, oERR=0.
- RAM outputs are registered. A read issued at edge k has its data sampled from iRAM_RDATA at edge k+RD_LAT and pushed into the FIFO.
  - An RD_LAT-bit valid shift register tracks in-flight reads.
- Credit = FIFO level + in-flight reads. A read may issue only if credit < FIFO_DEPTH, so the FIFO never overflows.
- FSM states:
  - IDLE: reads never issue; a pending iWR_REQ is granted every cycle. iFRAME_START -> PRIME.
  - PRIME: writes blocked. Issue sequential reads from fetch address 0 while credit allows. When FIFO level == FIFO_DEPTH -> RUN.
  - RUN, each cycle: issue a read if credit < FIFO_DEPTH and (credit < LOW_WM or !iWR_REQ); otherwise grant the write if iWR_REQ.
    - Fetch address increments per issued read.
    - After the read at address H_ACTIVE*V_ACTIVE-1 issues -> DONE.
  - DONE: no reads; writes granted every cycle; the FIFO drains via pops. iFRAME_START -> PRIME.
- Frame start during PRIME or RUN:
  - Flush the FIFO, discard in-flight reads (clear the valid pipe), reset the fetch address to 0.
  - Set oERR[1], enter PRIME.
- Write grant: oRAM_EN=1, oRAM_WE=1, oRAM_ADDR/oRAM_WDATA take the writer values, and oWR_ACK=1, all on the same edge.
  - At most one RAM access per cycle; oWR_ACK never asserts in two consecutive cycles for one held request unless iWR_REQ is still high after the ack.
  - The writer must drop iWR_REQ or present new data in the cycle after the ack.
- Pop: iPIX_REQ with FIFO non-empty -> oPIX_DATA = FIFO head at the next edge.
  - iPIX_REQ with FIFO empty -> oPIX_DATA=0, oERR[0] set; level unchanged.
  - Simultaneous push and pop: level unchanged, data order preserved.
- oPIX_DATA holds its value when there is no pop.
- oERR bits clear only on reset.
- Cycles with no access: oRAM_EN=0, oRAM_WE=0; address and data hold.

Test Plan:
- Reset mid-RUN (SYNC_RST_N low 3 cycles), RD_LAT=2 -> all outputs 0, IDLE. The next iFRAME_START gives reads at addresses 0..15 on consecutive clocks with no write grants; RUN is entered 2 clocks after the last read.
- RUN, writer held high, no pops -> zero RAM reads. 4 pops -> level drops to 12, writer keeps winning. 9 more pops (level 3 < LOW_WM) -> the next cycle is a read, and the write ack is delayed.
- Full-frame stream, one pop per cycle for 640 clocks then 160 idle, repeated 480 lines -> oPIX_DATA equals RAM[0..307199] in order, oERR=0, state DONE.
- 20 pops right after reset with no frame start -> oPIX_DATA=0 and oERR=01 after the first pop.
- iFRAME_START pulsed when fetch address = 100 with 2 reads in flight -> FIFO flushed, stale data never appears, the next 16 reads start at address 0, oERR[1]=1.
- Write at address 0x12345, data 0xA5 in IDLE -> on the next edge oRAM_EN=1, oRAM_WE=1, oRAM_ADDR=0x12345, oRAM_WDATA=0xA5, oWR_ACK=1 for exactly one clock.
